// File: rtl/row_buf_ctrl.sv
// -----------------------------------------------------------------------------
// row_buf_ctrl
//
// Sequencing controller for a single-row true dual-port line-buffer RAM.
// Each accepted raster pixel is written into the row buffer (port A) one
// cycle after it arrives, while the pixel at the same column of the previous
// row is read back through port B in the arrival cycle. The block emits
// vertically aligned pixel pairs (current, above) two cycles after the input.
//
// Build option:
//   ROW_BUF_BORDER_REPLICATE_EN - when defined, row 0 also produces output
//                                 pairs with o_win_up = o_win_cur.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_pix_valid        input pixel qualifier (gaps allowed, no backpressure)
//   i_pix_data         input pixel
//   i_sof              start of frame, qualified by i_pix_valid
//   addra/wea/dina     RAM port A (write), registered one cycle after input
//   addrb/enb          RAM port B (read), combinational in the input cycle
//   doutb              RAM port B read data, one cycle after enb
//   o_win_valid        output pair qualifier
//   o_win_cur/o_win_up current-row pixel and same-column pixel one row above
//   o_win_col/o_win_row  position of o_win_cur
//   o_eol              marks the last column of an output row
//   o_frame_done       one-cycle pulse with the final write of the frame
// -----------------------------------------------------------------------------
module row_buf_ctrl #(
    parameter int P_ROW_WIDTH     = 256,
    parameter int P_ROW_NUM       = 256,
    parameter int P_DATA_WIDTH    = 8,
    parameter int P_ADDR_WIDTH    = 12,
    parameter int P_ROW_CNT_WIDTH = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_pix_valid,
    input  logic [P_DATA_WIDTH-1:0]    i_pix_data,
    input  logic                       i_sof,
    output logic [P_ADDR_WIDTH-1:0]    addra,
    output logic                       wea,
    output logic [P_DATA_WIDTH-1:0]    dina,
    output logic [P_ADDR_WIDTH-1:0]    addrb,
    output logic                       enb,
    input  logic [P_DATA_WIDTH-1:0]    doutb,
    output logic                       o_win_valid,
    output logic [P_DATA_WIDTH-1:0]    o_win_cur,
    output logic [P_DATA_WIDTH-1:0]    o_win_up,
    output logic [P_ADDR_WIDTH-1:0]    o_win_col,
    output logic [P_ROW_CNT_WIDTH-1:0] o_win_row,
    output logic                       o_eol,
    output logic                       o_frame_done
);

    localparam logic [P_ADDR_WIDTH-1:0]    COL_LAST = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
    localparam logic [P_ROW_CNT_WIDTH-1:0] ROW_LAST = P_ROW_CNT_WIDTH'(P_ROW_NUM - 1);
    localparam logic [P_ADDR_WIDTH-1:0]    COL_ONE  = P_ADDR_WIDTH'(1);
    localparam logic [P_ROW_CNT_WIDTH-1:0] ROW_ONE  = P_ROW_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ---------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------
    state_t                     state_q, state_d;
    logic [P_ADDR_WIDTH-1:0]    col_q, col_d;
    logic [P_ROW_CNT_WIDTH-1:0] row_q, row_d;

    // Position/state that applies to the pixel on the inputs this cycle.
    // A qualified i_sof overrides the counters so the pixel is taken as (0,0).
    state_t                     state_eff_s;
    logic [P_ADDR_WIDTH-1:0]    col_eff_s;
    logic [P_ROW_CNT_WIDTH-1:0] row_eff_s;
    logic                       active_s;
    logic                       accept_s;
    logic                       col_wrap_s;
    logic                       rd_s;
    logic                       emit_s;
    logic                       rep_s;
    logic                       last_pix_s;

    // ---------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------
    // Write stage (T+1)
    logic                       wea_q, wea_d;
    logic [P_ADDR_WIDTH-1:0]    addra_q, addra_d;
    logic [P_DATA_WIDTH-1:0]    dina_q, dina_d;
    logic                       frame_done_q, frame_done_d;
    // Alignment stage (T+1), carries the current pixel alongside the read
    logic                       p1_valid_q, p1_valid_d;
    logic                       p1_rep_q, p1_rep_d;
    logic [P_DATA_WIDTH-1:0]    p1_cur_q, p1_cur_d;
    logic [P_ADDR_WIDTH-1:0]    p1_col_q, p1_col_d;
    logic [P_ROW_CNT_WIDTH-1:0] p1_row_q, p1_row_d;
    // Output stage (T+2)
    logic                       win_valid_q, win_valid_d;
    logic [P_DATA_WIDTH-1:0]    win_cur_q, win_cur_d;
    logic [P_DATA_WIDTH-1:0]    win_up_q, win_up_d;
    logic [P_ADDR_WIDTH-1:0]    win_col_q, win_col_d;
    logic [P_ROW_CNT_WIDTH-1:0] win_row_q, win_row_d;
    logic                       eol_q, eol_d;

    // Resolve the effective position of the incoming pixel and whether it is accepted
    always_comb begin
        state_eff_s = state_q;
        col_eff_s   = col_q;
        row_eff_s   = row_q;
        if (i_pix_valid && i_sof) begin
            state_eff_s = ST_FILL;
            col_eff_s   = {P_ADDR_WIDTH{1'b0}};
            row_eff_s   = {P_ROW_CNT_WIDTH{1'b0}};
        end else begin
            state_eff_s = state_q;
            col_eff_s   = col_q;
            row_eff_s   = row_q;
        end

        case (state_eff_s)
            ST_FILL:   active_s = 1'b1;
            ST_STREAM: active_s = 1'b1;
            ST_IDLE:   active_s = 1'b0;
            ST_DONE:   active_s = 1'b0;
            default:   active_s = 1'b0;
        endcase

        accept_s   = i_pix_valid && active_s;
        col_wrap_s = (col_eff_s == COL_LAST);
        rd_s       = accept_s && (state_eff_s == ST_STREAM);
        last_pix_s = rd_s && col_wrap_s && (row_eff_s == ROW_LAST);

`ifdef ROW_BUF_BORDER_REPLICATE_EN
        // Row 0 is emitted too; its "above" pixel is the pixel itself.
        emit_s = accept_s;
        rep_s  = accept_s && (state_eff_s == ST_FILL);
`else
        emit_s = rd_s;
        rep_s  = 1'b0;
`endif
    end

    // Next-state logic for the FSM and the column/row counters
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept_s) begin
            if (col_wrap_s) begin
                col_d = {P_ADDR_WIDTH{1'b0}};
                if ((state_eff_s == ST_STREAM) && (row_eff_s == ROW_LAST)) begin
                    row_d   = {P_ROW_CNT_WIDTH{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_eff_s + ROW_ONE;
                    state_d = ST_STREAM;
                end
            end else begin
                col_d   = col_eff_s + COL_ONE;
                row_d   = row_eff_s;
                state_d = state_eff_s;
            end
        end else begin
            state_d = state_q;
            col_d   = col_q;
            row_d   = row_q;
        end
    end

    // FSM and counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            col_q   <= {P_ADDR_WIDTH{1'b0}};
            row_q   <= {P_ROW_CNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Read port: issued in the arrival cycle so doutb lines up with the write stage.
    // Port A writes column c one cycle later, so A and B never hit the same
    // column in the same cycle.
    assign enb   = rd_s;
    assign addrb = col_eff_s;

    // Next values for the write and alignment stages; data holds when idle
    always_comb begin
        wea_d        = accept_s;
        frame_done_d = last_pix_s;
        p1_valid_d   = emit_s;
        p1_rep_d     = rep_s;
        if (accept_s) begin
            addra_d  = col_eff_s;
            dina_d   = i_pix_data;
            p1_cur_d = i_pix_data;
            p1_col_d = col_eff_s;
            p1_row_d = row_eff_s;
        end else begin
            addra_d  = addra_q;
            dina_d   = dina_q;
            p1_cur_d = p1_cur_q;
            p1_col_d = p1_col_q;
            p1_row_d = p1_row_q;
        end
    end

    // Next values for the output stage: pair the delayed pixel with the RAM read data
    always_comb begin
        win_valid_d = p1_valid_q;
        eol_d       = p1_valid_q && (p1_col_q == COL_LAST);
        if (p1_valid_q) begin
            win_cur_d = p1_cur_q;
            win_col_d = p1_col_q;
            win_row_d = p1_row_q;
            if (p1_rep_q) begin
                win_up_d = p1_cur_q;
            end else begin
                win_up_d = doutb;
            end
        end else begin
            win_cur_d = win_cur_q;
            win_up_d  = win_up_q;
            win_col_d = win_col_q;
            win_row_d = win_row_q;
        end
    end

    // Pipeline registers; reset flushes any pending write and output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wea_q        <= 1'b0;
            addra_q      <= {P_ADDR_WIDTH{1'b0}};
            dina_q       <= {P_DATA_WIDTH{1'b0}};
            frame_done_q <= 1'b0;
            p1_valid_q   <= 1'b0;
            p1_rep_q     <= 1'b0;
            p1_cur_q     <= {P_DATA_WIDTH{1'b0}};
            p1_col_q     <= {P_ADDR_WIDTH{1'b0}};
            p1_row_q     <= {P_ROW_CNT_WIDTH{1'b0}};
            win_valid_q  <= 1'b0;
            win_cur_q    <= {P_DATA_WIDTH{1'b0}};
            win_up_q     <= {P_DATA_WIDTH{1'b0}};
            win_col_q    <= {P_ADDR_WIDTH{1'b0}};
            win_row_q    <= {P_ROW_CNT_WIDTH{1'b0}};
            eol_q        <= 1'b0;
        end else begin
            wea_q        <= wea_d;
            addra_q      <= addra_d;
            dina_q       <= dina_d;
            frame_done_q <= frame_done_d;
            p1_valid_q   <= p1_valid_d;
            p1_rep_q     <= p1_rep_d;
            p1_cur_q     <= p1_cur_d;
            p1_col_q     <= p1_col_d;
            p1_row_q     <= p1_row_d;
            win_valid_q  <= win_valid_d;
            win_cur_q    <= win_cur_d;
            win_up_q     <= win_up_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            eol_q        <= eol_d;
        end
    end

    assign wea          = wea_q;
    assign addra        = addra_q;
    assign dina         = dina_q;
    assign o_frame_done = frame_done_q;
    assign o_win_valid  = win_valid_q;
    assign o_win_cur    = win_cur_q;
    assign o_win_up     = win_up_q;
    assign o_win_col    = win_col_q;
    assign o_win_row    = win_row_q;
    assign o_eol        = eol_q;

endmodule

// File: tb/tb_row_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_row_buf_ctrl
//
// Self-checking bench for row_buf_ctrl with a 4x3 frame and a 1-cycle RAM
// model. A table holds the expected outputs of the basic continuous frame;
// a frame-level reference model (pixel index, stored previous row) checks
// every cycle of every scenario, including randomized traffic.
// -----------------------------------------------------------------------------
module tb_row_buf_ctrl;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int RW = 12;
`ifdef ROW_BUF_BORDER_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_pix_valid = 1'b0;
    logic [DW-1:0] i_pix_data = '0;
    logic          i_sof = 1'b0;
    logic [AW-1:0] addra, addrb, o_win_col;
    logic          wea, enb, o_win_valid, o_eol, o_frame_done;
    logic [DW-1:0] dina, doutb, o_win_cur, o_win_up;
    logic [RW-1:0] o_win_row;

    row_buf_ctrl #(
        .P_ROW_WIDTH(W), .P_ROW_NUM(N), .P_DATA_WIDTH(DW),
        .P_ADDR_WIDTH(AW), .P_ROW_CNT_WIDTH(RW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_valid(i_pix_valid),
        .i_pix_data(i_pix_data), .i_sof(i_sof),
        .addra(addra), .wea(wea), .dina(dina),
        .addrb(addrb), .enb(enb), .doutb(doutb),
        .o_win_valid(o_win_valid), .o_win_cur(o_win_cur), .o_win_up(o_win_up),
        .o_win_col(o_win_col), .o_win_row(o_win_row),
        .o_eol(o_eol), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural 1-cycle RAM
    logic [DW-1:0] mem [0:W-1];
    always @(posedge i_clk) begin
        if (wea) mem[addra[1:0]] <= dina;
        if (enb) doutb <= mem[addrb[1:0]];
    end

    int n_checks = 0;
    int n_err    = 0;
    int out_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic valid;
        int   cur, up, col, row;
    } win_t;
    typedef struct {
        logic wea;
        int   addr, data;
        logic fd;
    } wr_t;

    bit   m_active;
    int   m_k;
    int   rowbuf [W];
    win_t s1, oo;
    wr_t  ow;

    task automatic model_clear();
        m_active = 1'b0;
        m_k = 0;
        s1 = '{1'b0, 0, 0, 0, 0};
        oo = '{1'b0, 0, 0, 0, 0};
        ow = '{1'b0, 0, 0, 1'b0};
    endtask

    // Drive one cycle's inputs, check all outputs against the model, advance model.
    // Leaves time just after the drive point; caller advances the clock.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic s);
        logic acc, e_enb, emit;
        int   col, row;
        win_t nw;
        wr_t  nwr;
        i_pix_valid = v;
        i_pix_data  = d;
        i_sof       = s;
        #1;
        acc = v && (s || m_active);
        if (acc && s) begin
            m_active = 1'b1;
            m_k = 0;
        end
        col   = m_k % W;
        row   = m_k / W;
        e_enb = acc && (row > 0);
        chk("enb", enb, e_enb);
        if (e_enb) chk("addrb", addrb, col);
        chk("wea", wea, ow.wea);
        if (ow.wea) begin
            chk("addra", addra, ow.addr);
            chk("dina", dina, ow.data);
        end
        chk("frame_done", o_frame_done, ow.fd);
        chk("win_valid", o_win_valid, oo.valid);
        chk("eol", o_eol, oo.valid && (oo.col == W - 1));
        if (oo.valid) begin
            chk("win_cur", o_win_cur, oo.cur);
            chk("win_up", o_win_up, oo.up);
            chk("win_col", o_win_col, oo.col);
            chk("win_row", o_win_row, oo.row);
        end
        if (o_win_valid) out_cnt++;
        oo  = s1;
        nw  = '{1'b0, 0, 0, 0, 0};
        nwr = '{1'b0, 0, 0, 1'b0};
        if (acc) begin
            emit = (row > 0) || REP;
            nw   = '{emit, int'(d), (row > 0) ? rowbuf[col] : int'(d), col, row};
            nwr  = '{1'b1, col, int'(d), (m_k == W * N - 1)};
            rowbuf[col] = int'(d);
            m_k++;
            if (m_k == W * N) begin
                m_active = 1'b0;
                m_k = 0;
            end
        end
        s1 = nw;
        ow = nwr;
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_pix_valid = 1'b0;
        i_sof = 1'b0;
        #1;
        chk("rst_wea", wea, 1'b0);
        chk("rst_enb", enb, 1'b0);
        chk("rst_addra", addra, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_dina", dina, 0);
        chk("rst_win_valid", o_win_valid, 1'b0);
        chk("rst_win_cur", o_win_cur, 0);
        chk("rst_win_up", o_win_up, 0);
        chk("rst_win_col", o_win_col, 0);
        chk("rst_win_row", o_win_row, 0);
        chk("rst_eol", o_eol, 1'b0);
        chk("rst_frame_done", o_frame_done, 1'b0);
        model_clear();
        tick();
        i_rst_n = 1'b1;
    endtask

    // ---------------- scenario-1 vector table ----------------
    typedef struct {
        logic v;
        logic [DW-1:0] d;
        logic s;
        logic e_valid;
        int   e_cur, e_up, e_col, e_row;
        logic e_eol, e_fd;
    } vec_t;
    vec_t tbl [14];

    task automatic run_table();
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].s);
            chk("tbl_valid", o_win_valid, tbl[i].e_valid);
            chk("tbl_eol", o_eol, tbl[i].e_eol);
            chk("tbl_frame_done", o_frame_done, tbl[i].e_fd);
            if (tbl[i].e_valid) begin
                chk("tbl_cur", o_win_cur, tbl[i].e_cur);
                chk("tbl_up", o_win_up, tbl[i].e_up);
                chk("tbl_col", o_win_col, tbl[i].e_col);
                chk("tbl_row", o_win_row, tbl[i].e_row);
            end
            tick();
        end
    endtask

    initial begin
        int first_out, cnt0, p;
        logic v, s;
        first_out = REP ? 1 : 5;
        // Pixel p (1..12) arrives at cycle p-1 and appears at cycle p+1.
        for (int c = 0; c < 14; c++) begin
            p = c - 1;
            tbl[c].v = (c < 12);
            tbl[c].d = DW'(c + 1);
            tbl[c].s = (c == 0);
            tbl[c].e_valid = (p >= first_out) && (p <= 12);
            tbl[c].e_cur = p;
            tbl[c].e_up  = (p > 4) ? p - 4 : p;
            tbl[c].e_col = (p - 1) % W;
            tbl[c].e_row = (p - 1) / W;
            tbl[c].e_eol = tbl[c].e_valid && ((p - 1) % W == W - 1);
            tbl[c].e_fd  = (c == 12);
        end
        for (int i = 0; i < W; i++) begin
            mem[i] = '0;
            rowbuf[i] = 0;
        end
        model_clear();

        tick();
        do_reset();

        // Pixels without i_sof after reset: ignored
        cnt0 = out_cnt;
        for (int i = 0; i < 5; i++) begin step(1'b1, DW'(50 + i), 1'b0); tick(); end
        chk("no_sof_after_reset_outputs", out_cnt, cnt0);

        // Continuous frame 1..12
        cnt0 = out_cnt;
        run_table();
        chk("frame1_out_count", out_cnt - cnt0, REP ? 12 : 8);

        // Pixels without i_sof after frame done: ignored
        cnt0 = out_cnt;
        for (int i = 0; i < 5; i++) begin step(1'b1, DW'(60 + i), 1'b0); tick(); end
        for (int i = 0; i < 2; i++) begin step(1'b0, '0, 1'b0); tick(); end
        chk("no_sof_after_done_outputs", out_cnt, cnt0);

        // Same frame with a 1-cycle gap after every pixel
        cnt0 = out_cnt;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, DW'(i + 1), i == 0); tick();
            step(1'b0, '0, 1'b0); tick();
        end
        for (int i = 0; i < 3; i++) begin step(1'b0, '0, 1'b0); tick(); end
        chk("gap_out_count", out_cnt - cnt0, REP ? 12 : 8);

        // Mid-frame restart at pixel 7 with values 100..111
        cnt0 = out_cnt;
        for (int i = 0; i < 6; i++) begin step(1'b1, DW'(i + 1), i == 0); tick(); end
        for (int i = 0; i < 12; i++) begin step(1'b1, DW'(100 + i), i == 0); tick(); end
        for (int i = 0; i < 3; i++) begin step(1'b0, '0, 1'b0); tick(); end
        chk("restart_out_count", out_cnt - cnt0, REP ? 18 : 10);

        // Reset mid-row 1, then the basic frame again
        for (int i = 0; i < 6; i++) begin step(1'b1, DW'(i + 1), i == 0); tick(); end
        do_reset();
        run_table();

        // Randomized traffic
        step(1'b1, DW'($urandom_range(0, 255)), 1'b1); tick();
        for (int i = 0; i < 800; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = v && ($urandom_range(0, 39) == 0);
            step(v, DW'($urandom_range(0, 255)), s);
            tick();
        end
        for (int i = 0; i < 3; i++) begin step(1'b0, '0, 1'b0); tick(); end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
